// File: rtl/drfm_cfg_sequencer.sv
// DRFM configuration sequencer: accepts toggle-handshaked command words from the
// JTAG (TCK) domain and applies the flagged fields atomically on a datapath frame boundary.
module drfm_cfg_sequencer #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             aclr,
    input  logic [31:0]      cmd_word,
    input  logic             cmd_toggle,
    input  logic             frame_sync,
    input  logic             err_clr,
    output logic             ack_toggle,
    output logic             busy,
    output logic [6:0]       delay_cfg,
    output logic [6:0]       doppler_cfg,
    output logic [6:0]       scale_cfg,
    output logic [6:0]       atten_cfg,
    output logic             cfg_load,
    output logic [3:0]       mode,
    output logic             err_timeout,
    output logic             err_overrun,
    output logic [CNT_W-1:0] cmd_count
);

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT_FRAME,
        S_APPLY,
        S_ACK
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              tog_sync1;
    logic              tog_sync2;
    logic              tog_prev;
    logic              tog_edge;
    logic [31:0]       cmd_q;
    logic              pending;
    logic [TMO_W-1:0]  wait_cnt;
    logic              any_flag;
    logic              do_capture;
    logic              do_apply;
    logic              do_ack;
    logic              timeout_hit;
    logic [3:0]        mode_apply;

    assign tog_edge = tog_sync2 ^ tog_prev;
    assign busy     = (state != S_IDLE);
    assign any_flag = cmd_q[7] | cmd_q[15] | cmd_q[23] | cmd_q[31];

    // cmd_toggle crosses from TCK: two synchronizer flops, then a history flop for edge detection
    always_ff @(posedge CLK or negedge aclr) begin
        if (!aclr) begin
            tog_sync1 <= 1'b0;
            tog_sync2 <= 1'b0;
            tog_prev  <= 1'b0;
        end else begin
            tog_sync1 <= cmd_toggle;
            tog_sync2 <= tog_sync1;
            tog_prev  <= tog_sync2;
        end
    end

    always_ff @(posedge CLK or negedge aclr) begin
        if (!aclr) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Each state's action is registered on the edge that enters it, hence the do_* strobes
    always_comb begin
        state_next  = state;
        do_capture  = 1'b0;
        do_apply    = 1'b0;
        do_ack      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (tog_edge || pending) begin
                    state_next = S_CAPTURE;
                    do_capture = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (any_flag) begin
                    state_next = S_WAIT_FRAME;
                end else begin
                    state_next = S_ACK;
                    do_ack     = 1'b1;
                end
            end
            S_WAIT_FRAME: begin
                if (frame_sync) begin
                    state_next = S_APPLY;
                    do_apply   = 1'b1;
                end else if (wait_cnt >= TMO_LAST) begin
                    state_next  = S_APPLY;
                    do_apply    = 1'b1;
                    timeout_hit = 1'b1;
                end
            end
            S_APPLY: begin
                state_next = S_ACK;
                do_ack     = 1'b1;
            end
            S_ACK: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mode_apply = 4'b0000;
        if (cmd_q[7]) begin
            mode_apply = 4'b0001;
        end else if (cmd_q[15]) begin
            mode_apply = 4'b1000;
        end else if (cmd_q[23]) begin
            mode_apply = 4'b0010;
        end else if (cmd_q[31]) begin
            mode_apply = 4'b0100;
        end
    end

    // Counts cycles since CAPTURE so the forced apply lands TIMEOUT cycles after capture
    always_ff @(posedge CLK or negedge aclr) begin
        if (!aclr) begin
            wait_cnt <= '0;
        end else if (do_capture) begin
            wait_cnt <= '0;
        end else if (state == S_CAPTURE || state == S_WAIT_FRAME) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge aclr) begin
        if (!aclr) begin
            cmd_q       <= '0;
            pending     <= 1'b0;
            delay_cfg   <= '0;
            doppler_cfg <= '0;
            scale_cfg   <= '0;
            atten_cfg   <= '0;
            cfg_load    <= 1'b0;
            mode        <= '0;
            ack_toggle  <= 1'b0;
            cmd_count   <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            cfg_load <= 1'b0;
            if (do_capture) begin
                cmd_q <= cmd_word;
            end
            if (do_apply) begin
                if (cmd_q[7]) begin
                    delay_cfg <= cmd_q[6:0];
                end
                if (cmd_q[15]) begin
                    doppler_cfg <= cmd_q[14:8];
                end
                if (cmd_q[23]) begin
                    scale_cfg <= cmd_q[22:16];
                end
                if (cmd_q[31]) begin
                    atten_cfg <= cmd_q[30:24];
                end
                cfg_load <= 1'b1;
                mode     <= mode_apply;
            end
            if (do_ack) begin
                ack_toggle <= ~ack_toggle;
                cmd_count  <= cmd_count + 1'b1;
                if (state == S_CAPTURE) begin
                    mode <= 4'b0000;
                end
            end
            // A toggle seen mid-command is remembered and replayed once back in IDLE
            if (do_capture) begin
                pending <= 1'b0;
            end else if (tog_edge && busy) begin
                pending <= 1'b1;
            end
            if (tog_edge && busy) begin
                err_overrun <= 1'b1;
            end else if (err_clr) begin
                err_overrun <= 1'b0;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_drfm_cfg_sequencer.sv
// Directed self-checking bench for drfm_cfg_sequencer with TIMEOUT=16 and a 4-bit
// command counter so the wrap can be reached in a few commands.
module tb_drfm_cfg_sequencer;

    logic        CLK;
    logic        aclr;
    logic [31:0] cmd_word;
    logic        cmd_toggle;
    logic        frame_sync;
    logic        err_clr;
    logic        ack_toggle;
    logic        busy;
    logic [6:0]  delay_cfg;
    logic [6:0]  doppler_cfg;
    logic [6:0]  scale_cfg;
    logic [6:0]  atten_cfg;
    logic        cfg_load;
    logic [3:0]  mode;
    logic        err_timeout;
    logic        err_overrun;
    logic [3:0]  cmd_count;

    int checkCount = 0;
    int passCount  = 0;
    int cycleCnt   = 0;
    int loadCount  = 0;
    int toggleCycle = 0;
    int captureCycle = 0;
    int loadCycle  = 0;
    int ackCycle   = 0;
    logic busyPrev = 1'b0;
    logic ackPrev  = 1'b0;

    drfm_cfg_sequencer #(
        .TIMEOUT(16),
        .CNT_W  (4)
    ) dut (
        .CLK        (CLK),
        .aclr       (aclr),
        .cmd_word   (cmd_word),
        .cmd_toggle (cmd_toggle),
        .frame_sync (frame_sync),
        .err_clr    (err_clr),
        .ack_toggle (ack_toggle),
        .busy       (busy),
        .delay_cfg  (delay_cfg),
        .doppler_cfg(doppler_cfg),
        .scale_cfg  (scale_cfg),
        .atten_cfg  (atten_cfg),
        .cfg_load   (cfg_load),
        .mode       (mode),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun),
        .cmd_count  (cmd_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleCnt++;

    // Timestamps are taken on the falling edge, counted in rising edges seen so far
    always @(negedge CLK) begin
        if (busy && !busyPrev) captureCycle = cycleCnt;
        if (cfg_load) begin
            loadCount++;
            loadCycle = cycleCnt;
        end
        if (ack_toggle != ackPrev) ackCycle = cycleCnt;
        busyPrev = busy;
        ackPrev  = ack_toggle;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        cmd_word    = word;
        cmd_toggle  = ~cmd_toggle;
        toggleCycle = cycleCnt;
    endtask

    task automatic waitAck(input string tag, input int maxCycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            tick();
            if (ack_toggle == cmd_toggle && !busy) done = 1'b1;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic waitBusy(input string tag, input int maxCycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            tick();
            if (busy) done = 1'b1;
        end
        checkOutput({tag, "_busy"}, 32'(done), 32'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ack"},   32'(ack_toggle), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy), 32'd0);
        checkOutput({tag, "_cfgs"},  32'({delay_cfg, doppler_cfg, scale_cfg, atten_cfg}), 32'd0);
        checkOutput({tag, "_load"},  32'(cfg_load), 32'd0);
        checkOutput({tag, "_mode"},  32'(mode), 32'd0);
        checkOutput({tag, "_errs"},  32'({err_timeout, err_overrun}), 32'd0);
        checkOutput({tag, "_count"}, 32'(cmd_count), 32'd0);
    endtask

    initial begin
        int loadBase;
        aclr       = 1'b0;
        cmd_word   = 32'h0;
        cmd_toggle = 1'b0;
        frame_sync = 1'b1;
        err_clr    = 1'b0;
        repeat (3) tick();
        checkResetState("reset");
        aclr = 1'b1;
        repeat (2) tick();

        // Delay-only command with frame_sync high: checks the handshake latencies
        loadBase = loadCount;
        applyStimulus(32'h0000_0085);
        waitAck("t1", 40);
        checkOutput("t1_cap_lat",  32'(captureCycle - toggleCycle), 32'd3);
        checkOutput("t1_load_lat", 32'(loadCycle - captureCycle), 32'd2);
        checkOutput("t1_ack_lat",  32'(ackCycle - loadCycle), 32'd1);
        checkOutput("t1_loads",    32'(loadCount - loadBase), 32'd1);
        checkOutput("t1_delay",    32'(delay_cfg), 32'h05);
        checkOutput("t1_others",   32'({doppler_cfg, scale_cfg, atten_cfg}), 32'd0);
        checkOutput("t1_mode",     32'(mode), 32'b0001);
        checkOutput("t1_ack",      32'(ack_toggle), 32'd1);
        checkOutput("t1_count",    32'(cmd_count), 32'd1);

        // Scale and atten flagged: scale outranks atten for the mode code
        loadBase = loadCount;
        applyStimulus(32'h8A80_0000);
        waitAck("t2", 40);
        checkOutput("t2_loads", 32'(loadCount - loadBase), 32'd1);
        checkOutput("t2_scale", 32'(scale_cfg), 32'h00);
        checkOutput("t2_atten", 32'(atten_cfg), 32'h0A);
        checkOutput("t2_delay", 32'(delay_cfg), 32'h05);
        checkOutput("t2_mode",  32'(mode), 32'b0010);
        checkOutput("t2_tmo",   32'(err_timeout), 32'd0);
        checkOutput("t2_count", 32'(cmd_count), 32'd2);

        // No frame_sync: apply is forced TIMEOUT cycles after capture
        frame_sync = 1'b0;
        loadBase = loadCount;
        applyStimulus(32'h0000_9300);
        waitAck("t3", 60);
        frame_sync = 1'b1;
        checkOutput("t3_load_lat", 32'(loadCycle - captureCycle), 32'd16);
        checkOutput("t3_loads",    32'(loadCount - loadBase), 32'd1);
        checkOutput("t3_doppler",  32'(doppler_cfg), 32'h13);
        checkOutput("t3_mode",     32'(mode), 32'b1000);
        checkOutput("t3_tmo",      32'(err_timeout), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        checkOutput("t3_tmo_clr",  32'(err_timeout), 32'd0);

        // Flag-less command: acknowledged without a load, mode cleared
        loadBase = loadCount;
        applyStimulus(32'h0000_0000);
        waitAck("t4", 40);
        checkOutput("t4_loads", 32'(loadCount - loadBase), 32'd0);
        checkOutput("t4_mode",  32'(mode), 32'b0000);
        checkOutput("t4_ack",   32'(ack_toggle), 32'd0);
        checkOutput("t4_count", 32'(cmd_count), 32'd4);

        // Second toggle lands while the first command is in flight
        loadBase = loadCount;
        checkOutput("t5_ovr_pre", 32'(err_overrun), 32'd0);
        applyStimulus(32'h0000_00AA);
        waitBusy("t5", 10);
        applyStimulus(32'h00C5_0000);
        waitAck("t5", 60);
        checkOutput("t5_ovr",   32'(err_overrun), 32'd1);
        checkOutput("t5_ack",   32'(ack_toggle), 32'd0);
        checkOutput("t5_loads", 32'(loadCount - loadBase), 32'd2);
        checkOutput("t5_delay", 32'(delay_cfg), 32'h2A);
        checkOutput("t5_scale", 32'(scale_cfg), 32'h45);
        checkOutput("t5_mode",  32'(mode), 32'b0010);
        checkOutput("t5_count", 32'(cmd_count), 32'd6);

        // Reset dropped while waiting for a frame boundary
        frame_sync = 1'b0;
        applyStimulus(32'h0000_0081);
        waitBusy("t6", 10);
        repeat (3) tick();
        checkOutput("t6_busy_pre", 32'(busy), 32'd1);
        loadBase = loadCount;
        aclr = 1'b0;
        cmd_toggle = 1'b0;
        #1;
        checkResetState("t6_rst");
        repeat (3) tick();
        aclr = 1'b1;
        frame_sync = 1'b1;
        repeat (3) tick();
        checkOutput("t6_loads", 32'(loadCount - loadBase), 32'd0);
        checkOutput("t6_idle",  32'(busy), 32'd0);
        applyStimulus(32'h0000_0087);
        waitAck("t6b", 40);
        checkOutput("t6_delay", 32'(delay_cfg), 32'h07);
        checkOutput("t6_mode",  32'(mode), 32'b0001);
        checkOutput("t6_ack",   32'(ack_toggle), 32'd1);
        checkOutput("t6_count", 32'(cmd_count), 32'd1);

        // Counter wraps from 15 to 0
        for (int i = 0; i < 15; i++) begin
            applyStimulus(32'h0000_0000);
            waitAck("t7", 40);
            if (i == 13) checkOutput("t7_count15", 32'(cmd_count), 32'd15);
        end
        checkOutput("t7_wrap", 32'(cmd_count), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
